e203_ifu_flushctrl: RTL



---
 rtl/e203_ifu_flushctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/e203_ifu_flushctrl.sv
// IFU-side flush/halt responder. Owns the fetch PC and the fetch request
// channel, counts outstanding fetches so that responses issued before a
// flush are flagged stale, and grants WFI halt only once the bus is quiet.
module e203_ifu_flushctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned OUTS_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        pipe_flush_req,
  input  logic [31:0] pipe_flush_add_op1,
  input  logic [31:0] pipe_flush_add_op2,
  output logic        pipe_flush_ack,

  input  logic        wfi_halt_ifu_req,
  output logic        wfi_halt_ifu_ack,

  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_pc,

  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_stale
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // fetching normally
    ST_DRAIN = 2'd1,  // waiting for pre-flush fetches to return
    ST_HALT  = 2'd2   // fetch halted for WFI, bus idle
  } state_e;

  localparam logic [1:0] OUTS_LIMIT = 2'(OUTS_MAX);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outs_cnt_q, outs_cnt_d;
  logic [1:0]  stale_cnt_q, stale_cnt_d;

  logic        flush_acc;
  logic        req_hsk;
  logic        rsp_hsk;
  logic [31:0] redirect_sum;

  // A flush is taken the same cycle it is presented, in any state.
  assign flush_acc      = pipe_flush_req & ~rst;
  assign pipe_flush_ack = flush_acc;

  assign ifu_req_valid  = (state_q == ST_RUN) & ~pipe_flush_req & ~wfi_halt_ifu_req
                        & (outs_cnt_q < OUTS_LIMIT) & ~rst;
  assign ifu_req_pc     = pc_q;
  assign req_hsk        = ifu_req_valid & ifu_req_ready;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign rsp_hsk        = ifu_rsp_valid & (outs_cnt_q != 2'd0);
  assign ifu_rsp_stale  = ifu_rsp_valid & (stale_cnt_q != 2'd0);

  assign wfi_halt_ifu_ack = (state_q == ST_HALT);

  // Redirect target: carry out of bit 31 is dropped, bit 0 forced low.
  assign redirect_sum = pipe_flush_add_op1 + pipe_flush_add_op2;

  // Fetch PC: redirect on flush, otherwise advance on each accepted request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pc_d = pc_q;
    if (flush_acc) begin
      pc_d = redirect_sum & ~32'h1;
    end else if (req_hsk) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Outstanding and stale fetch counters.
  always_comb begin
    outs_cnt_d  = outs_cnt_q;
    stale_cnt_d = stale_cnt_q;
    if (req_hsk && !rsp_hsk) begin
      outs_cnt_d = outs_cnt_q + 2'd1;
    end else if (!req_hsk && rsp_hsk) begin
      outs_cnt_d = outs_cnt_q - 2'd1;
    end
    if (flush_acc) begin
      // Everything still in flight after this cycle's response is stale.
      stale_cnt_d = outs_cnt_q - {1'b0, rsp_hsk};
    end else if (rsp_hsk && (stale_cnt_q != 2'd0)) begin
      stale_cnt_d = stale_cnt_q - 2'd1;
    end
  end

  // Next-state logic for RUN / DRAIN / HALT.
  always_comb begin
    state_d = state_q;
    if (flush_acc) begin
      if (wfi_halt_ifu_req && (stale_cnt_d == 2'd0)) begin
        state_d = ST_HALT;
      end else if (stale_cnt_d != 2'd0) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (wfi_halt_ifu_req && (outs_cnt_d == 2'd0)) state_d = ST_HALT;
        end
        ST_DRAIN: begin
          if (stale_cnt_d == 2'd0) state_d = wfi_halt_ifu_req ? ST_HALT : ST_RUN;
        end
        ST_HALT: begin
          if (!wfi_halt_ifu_req) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      outs_cnt_q  <= 2'd0;
      stale_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      outs_cnt_q  <= outs_cnt_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

endmodule
